// File: rtl/serial_shift_ctrl.sv
// Serial shift sequencer: drives an external clk_divider to clock a word out to the display driver.
// Build option: define SHIFT_LSB_FIRST_EN to send bit 0 first (default is MSB first).
module serial_shift_ctrl #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned BIT_CNT_WIDTH   = 4,
    parameter int unsigned LATCH_CYCLES    = 4,
    parameter int unsigned LATCH_CNT_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_abort_stb,
    output logic                  o_div_start_stb,
    output logic                  o_div_reset_stb,
    input  logic                  i_div_clk,
    input  logic                  i_div_clk_rose,
    output logic                  o_sclk,
    output logic                  o_sdata,
    output logic                  o_latch,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    localparam logic [BIT_CNT_WIDTH-1:0]   BIT_CNT_LAST   = BIT_CNT_WIDTH'(DATA_WIDTH);
    localparam logic [LATCH_CNT_WIDTH-1:0] LATCH_CNT_LAST = LATCH_CNT_WIDTH'(LATCH_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [DATA_WIDTH-1:0]      shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]      shreg_shifted;
    logic [BIT_CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [LATCH_CNT_WIDTH-1:0] latch_cnt_q, latch_cnt_d;
    logic                       latch_q, latch_d;
    logic                       start_stb_q, start_stb_d;
    logic                       div_reset_stb_q, div_reset_stb_d;
    logic                       busy_q, busy_d;
    logic                       accept;
    logic                       last_bit;
    logic                       latch_done;

    // The bit on the pin is read straight from the shift register's output end,
    // so clearing the register on return to IDLE also drives o_sdata low.
`ifdef SHIFT_LSB_FIRST_EN
    assign shreg_shifted = {1'b0, shreg_q[DATA_WIDTH-1:1]};
    assign o_sdata       = shreg_q[0];
`else
    assign shreg_shifted = {shreg_q[DATA_WIDTH-2:0], 1'b0};
    assign o_sdata       = shreg_q[DATA_WIDTH-1];
`endif

    assign o_ready         = (state_q == ST_IDLE) && i_reset_n;
    assign o_sclk          = (state_q == ST_SHIFT) ? i_div_clk : 1'b1;
    assign o_div_start_stb = start_stb_q;
    assign o_div_reset_stb = div_reset_stb_q;
    assign o_latch         = latch_q;
    assign o_busy          = busy_q;

    assign accept      = o_ready && i_valid && !i_abort_stb;
    assign bit_cnt_inc = bit_cnt_q + BIT_CNT_WIDTH'(1);
    assign last_bit    = i_div_clk_rose && (bit_cnt_inc == BIT_CNT_LAST);
    assign latch_done  = (latch_cnt_q == LATCH_CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q         <= ST_IDLE;
            shreg_q         <= '0;
            bit_cnt_q       <= '0;
            latch_cnt_q     <= '0;
            latch_q         <= 1'b0;
            start_stb_q     <= 1'b0;
            div_reset_stb_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            shreg_q         <= shreg_d;
            bit_cnt_q       <= bit_cnt_d;
            latch_cnt_q     <= latch_cnt_d;
            latch_q         <= latch_d;
            start_stb_q     <= start_stb_d;
            div_reset_stb_q <= div_reset_stb_d;
            busy_q          <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                state_d = i_abort_stb ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (i_abort_stb)   state_d = ST_IDLE;
                else if (last_bit) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (i_abort_stb || latch_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_d         = shreg_q;
        bit_cnt_d       = bit_cnt_q;
        latch_cnt_d     = latch_cnt_q;
        latch_d         = latch_q;
        start_stb_d     = 1'b0;
        div_reset_stb_d = 1'b0;
        busy_d          = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d     = i_data;
                    bit_cnt_d   = '0;
                    start_stb_d = 1'b1;
                end
            end
            ST_START: begin
                if (i_abort_stb) begin
                    div_reset_stb_d = 1'b1;
                    shreg_d         = '0;
                end
            end
            ST_SHIFT: begin
                if (i_abort_stb) begin
                    div_reset_stb_d = 1'b1;
                    shreg_d         = '0;
                end else if (i_div_clk_rose) begin
                    bit_cnt_d = bit_cnt_inc;
                    if (last_bit) begin
                        div_reset_stb_d = 1'b1;
                        latch_d         = 1'b1;
                        latch_cnt_d     = '0;
                    end else begin
                        shreg_d = shreg_shifted;
                    end
                end
            end
            ST_LATCH: begin
                // Divider is already stopped here, so an abort issues no strobe.
                if (i_abort_stb || latch_done) begin
                    latch_d = 1'b0;
                    shreg_d = '0;
                end else begin
                    latch_cnt_d = latch_cnt_q + LATCH_CNT_WIDTH'(1);
                end
            end
            default: begin
                shreg_d = '0;
                latch_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Self-checking bench for serial_shift_ctrl with a behavioural clk_divider (RATE=10) and pin monitor.
module tb_serial_shift_ctrl;

    localparam int DW    = 8;
    localparam int RATE  = 10;
    localparam int LATCH = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          abort_stb;
    logic          div_start_stb;
    logic          div_reset_stb;
    logic          div_clk;
    logic          div_rose;
    logic          sclk;
    logic          sdata;
    logic          latch;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    int   start_cnt, rst_cnt, rise_cnt, latch_hi, latch_pulses, viol;
    logic bits[$];

    serial_shift_ctrl #(
        .DATA_WIDTH     (DW),
        .BIT_CNT_WIDTH  (4),
        .LATCH_CYCLES   (LATCH),
        .LATCH_CNT_WIDTH(3)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_data         (data),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_abort_stb    (abort_stb),
        .o_div_start_stb(div_start_stb),
        .o_div_reset_stb(div_reset_stb),
        .i_div_clk      (div_clk),
        .i_div_clk_rose (div_rose),
        .o_sclk         (sclk),
        .o_sdata        (sdata),
        .o_latch        (latch),
        .o_busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider model plus pin monitor: sdata is captured at the instant sclk rises.
    initial begin
        logic running, prev_sclk, prev_start, prev_rst, prev_latch;
        int   dcnt;
        div_clk = 1'b1; div_rose = 1'b0; running = 1'b0; dcnt = 0;
        prev_sclk = 1'b1; prev_start = 1'b0; prev_rst = 1'b0; prev_latch = 1'b0;
        start_cnt = 0; rst_cnt = 0; rise_cnt = 0; latch_hi = 0; latch_pulses = 0; viol = 0;
        forever begin
            @(negedge clk);
            if (div_start_stb === 1'b1) start_cnt++;
            if (div_reset_stb === 1'b1) rst_cnt++;
            if (div_start_stb === 1'b1 && div_reset_stb === 1'b1) viol++;
            if ((div_start_stb === 1'b1 && prev_start) || (div_reset_stb === 1'b1 && prev_rst)) viol++;
            if (latch === 1'b1) latch_hi++;
            if (prev_latch && latch !== 1'b1) latch_pulses++;
            prev_start = (div_start_stb === 1'b1);
            prev_rst   = (div_reset_stb === 1'b1);
            prev_latch = (latch === 1'b1);
            if (!rst_n || div_reset_stb === 1'b1) begin
                running = 1'b0; div_clk = 1'b1; div_rose = 1'b0;
            end else if (div_start_stb === 1'b1) begin
                running = 1'b1; dcnt = 0; div_clk = 1'b0; div_rose = 1'b0;
            end else if (running) begin
                dcnt++;
                div_rose = 1'b0;
                if (dcnt == RATE) begin
                    dcnt     = 0;
                    div_clk  = ~div_clk;
                    div_rose = div_clk;
                end
            end else begin
                div_rose = 1'b0;
            end
            #1;
            if (sclk === 1'b1 && !prev_sclk) begin
                rise_cnt++;
                bits.push_back(sdata);
            end
            prev_sclk = (sclk === 1'b1);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        start_cnt = 0; rst_cnt = 0; rise_cnt = 0; latch_hi = 0; latch_pulses = 0;
        bits.delete();
    endtask

    // Reference: position i of the serial stream for word w.
    function automatic logic exp_bit(input logic [DW-1:0] w, input int i);
`ifdef SHIFT_LSB_FIRST_EN
        return logic'((w >> i) & 1);
`else
        return logic'((w >> (DW - 1 - i)) & 1);
`endif
    endfunction

    task automatic check_stream(input string tag, input logic [DW-1:0] words[$]);
        chk({tag, "_nbits"}, bits.size(), words.size() * DW);
        for (int w = 0; w < words.size(); w++)
            for (int i = 0; i < DW; i++)
                if (w * DW + i < bits.size())
                    chk($sformatf("%s_w%0d_b%0d", tag, w, i), bits[w*DW+i], exp_bit(words[w], i));
    endtask

    task automatic wait_ready(input string tag);
        for (int n = 0; n < 500 && ready !== 1'b1; n++) step();
        chk({tag, "_ready_to"}, ready, 1'b1);
    endtask

    task automatic do_word(input logic [DW-1:0] w, input string tag);
        logic [DW-1:0] q[$];
        clear_mon();
        data = w; valid = 1'b1;
        step();
        valid = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        wait_ready(tag);
        chk({tag, "_start"}, start_cnt, 1);
        chk({tag, "_rstb"}, rst_cnt, 1);
        chk({tag, "_rises"}, rise_cnt, DW);
        chk({tag, "_latch_len"}, latch_hi, LATCH);
        chk({tag, "_latch_n"}, latch_pulses, 1);
        chk({tag, "_sdata0"}, sdata, 1'b0);
        chk({tag, "_sclk1"}, sclk, 1'b1);
        q.push_back(w);
        check_stream(tag, q);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] w;
        rst_n = 1'b0; data = '0; valid = 1'b0; abort_stb = 1'b0;
        repeat (3) step();
        chk("rst_ready", ready, 1'b0);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_sdata", sdata, 1'b0);
        chk("rst_latch", latch, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", div_start_stb, 1'b0);
        chk("rst_rstb", div_reset_stb, 1'b0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", ready, 1'b1);

        clear_mon();
        for (int n = 0; n < 50; n++) begin
            step();
            chk("idle_ready", ready, 1'b1);
            chk("idle_sclk", sclk, 1'b1);
            chk("idle_latch", latch, 1'b0);
        end
        chk("idle_starts", start_cnt, 0);
        chk("idle_rstbs", rst_cnt, 0);

        do_word(8'hA5, "a5");
        do_word(8'h01, "w01");
        do_word(8'h80, "w80");

        // Abort after the third sclk rise.
        clear_mon();
        data = 8'hFF; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int n = 0; n < 200 && rise_cnt < 3; n++) step();
        chk("ab_rise3_to", rise_cnt, 3);
        abort_stb = 1'b1;
        step();
        abort_stb = 1'b0;
        chk("ab_rstb", div_reset_stb, 1'b1);
        chk("ab_ready", ready, 1'b1);
        chk("ab_sdata", sdata, 1'b0);
        chk("ab_busy", busy, 1'b0);
        repeat (30) step();
        chk("ab_nolatch", latch_hi, 0);
        chk("ab_rises", rise_cnt, 3);
        chk("ab_rstb_n", rst_cnt, 1);

        // Abort in START.
        clear_mon();
        data = 8'h5A; valid = 1'b1;
        step();
        valid = 1'b0; abort_stb = 1'b1;
        step();
        abort_stb = 1'b0;
        chk("abst_rstb", div_reset_stb, 1'b1);
        chk("abst_ready", ready, 1'b1);
        repeat (25) step();
        chk("abst_rises", rise_cnt, 0);
        chk("abst_start_n", start_cnt, 1);

        // Abort in LATCH: no divider strobe.
        clear_mon();
        data = 8'hC3; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int n = 0; n < 400 && latch !== 1'b1; n++) step();
        chk("abl_latch_to", latch, 1'b1);
        abort_stb = 1'b1;
        step();
        abort_stb = 1'b0;
        chk("abl_latch", latch, 1'b0);
        chk("abl_ready", ready, 1'b1);
        chk("abl_rstb", div_reset_stb, 1'b0);

        // Abort in IDLE blocks a same-cycle handshake.
        clear_mon();
        data = 8'h77; valid = 1'b1; abort_stb = 1'b1;
        step();
        valid = 1'b0; abort_stb = 1'b0;
        chk("abi_start", div_start_stb, 1'b0);
        chk("abi_ready", ready, 1'b1);
        chk("abi_busy", busy, 1'b0);

        // Back-to-back with i_valid held high.
        clear_mon();
        data = 8'h3C; valid = 1'b1;
        step();
        data = 8'h81;
        wait_ready("b2b1");
        chk("b2b_held_off", start_cnt, 1);
        chk("b2b_latch1", latch_pulses, 1);
        for (int n = 0; n < 10 && start_cnt < 2; n++) step();
        valid = 1'b0;
        chk("b2b_accept2", start_cnt, 2);
        wait_ready("b2b2");
        chk("b2b_rises", rise_cnt, 2 * DW);
        chk("b2b_latch", latch_hi, 2 * LATCH);
        q.delete(); q.push_back(8'h3C); q.push_back(8'h81);
        check_stream("b2b", q);

        // Reset mid-SHIFT.
        clear_mon();
        data = 8'hE7; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int n = 0; n < 200 && rise_cnt < 4; n++) step();
        chk("mr_rise4_to", rise_cnt, 4);
        rst_n = 1'b0;
        step();
        chk("mr_ready", ready, 1'b0);
        chk("mr_sclk", sclk, 1'b1);
        chk("mr_sdata", sdata, 1'b0);
        chk("mr_latch", latch, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_start", div_start_stb, 1'b0);
        chk("mr_rstb", div_reset_stb, 1'b0);
        rst_n = 1'b1;
        step();
        chk("mr_ready_after", ready, 1'b1);
        do_word(8'h55, "w55");

        for (int k = 0; k < 8; k++) begin
            w = DW'($urandom);
            repeat ($urandom_range(0, 5)) step();
            do_word(w, $sformatf("rnd%0d", k));
        end

        chk("strobe_rules", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
